// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared types and constants for the FIFO write-side command framer.
package fifo_wr_ctrl_pkg;
    localparam int DATA_SIZE_DFLT = 32;
    localparam int LEN_BITS_DFLT  = 8;
    localparam int LAST_BIT       = DATA_SIZE_DFLT;
    localparam int CNT_W          = 16;

    typedef enum logic {
        ST_IDLE,
        ST_PAYLOAD
    } frm_state_e;

    // Index of the last-of-packet flag for a given command width.
    function automatic int last_bit_of(input int data_size);
        return data_size;
    endfunction
endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Upstream command stream plus FIFO write-port signals of the framer.
interface fifo_wr_ctrl_if
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DFLT
);
    logic                 s_valid;
    logic                 s_ready;
    logic [DATA_SIZE-1:0] s_data;
    logic                 wfull;
    logic                 winc;
    logic [DATA_SIZE:0]   wdata;
    logic                 busy;
    logic [CNT_W-1:0]     pkt_count;

    modport master (
        output s_valid, s_data, wfull,
        input  s_ready, winc, wdata, busy, pkt_count
    );

    modport slave (
        input  s_valid, s_data, wfull,
        output s_ready, winc, wdata, busy, pkt_count
    );
endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer; ready is registered from next-cycle occupancy.
module fifo_skid_buf #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             ready
);
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic             ready_q, ready_d;

    always_comb begin
        occ_d = occ_q + 2'(push) - 2'(pop);
        e0_d  = e0_q;
        e1_d  = e1_q;
        if (pop) begin
            e0_d = e1_q;
            if (push) begin
                // With one entry the incoming word becomes the new head directly.
                if (occ_q == 2'd1) e0_d = din;
                else               e1_d = din;
            end
        end else if (push) begin
            if (occ_q == 2'd0) e0_d = din;
            else               e1_d = din;
        end
        ready_d = (occ_d < 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            ready_q <= ready_d;
        end
    end

    assign dout  = e0_q;
    assign empty = (occ_q == 2'd0);
    assign ready = ready_q;
endmodule

// File: rtl/fifo_wr_ctrl.sv
// Frames header/payload command words, tags last-of-packet and writes them to a FIFO.
module fifo_wr_ctrl
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DFLT,
    parameter int LEN_BITS  = LEN_BITS_DFLT
) (
    input  logic          wclk,
    input  logic          wrst,
    fifo_wr_ctrl_if.slave bus
);
    localparam int LB = last_bit_of(DATA_SIZE);

    frm_state_e           state_q, state_d;
    logic [LEN_BITS-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]     pkt_count_q, pkt_count_d;

    logic                 accept;
    logic                 pop;
    logic                 last_tag;
    logic [LEN_BITS-1:0]  hdr_len;
    logic                 buf_empty;
    logic                 buf_ready;
    logic [DATA_SIZE:0]   buf_dout;

    assign accept  = bus.s_valid & buf_ready;
    assign pop     = ~buf_empty & ~bus.wfull;
    assign hdr_len = bus.s_data[LEN_BITS-1:0];

    // The last tag is decided at accept time so the buffer carries it with the word.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        last_tag = 1'b0;
        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (hdr_len == '0) begin
                        last_tag = 1'b1;
                    end else begin
                        rem_d   = hdr_len;
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (rem_q == LEN_BITS'(1)) begin
                        last_tag = 1'b1;
                        rem_d    = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        rem_d = rem_q - LEN_BITS'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pkt_count_d = pkt_count_q;
        if (pop && buf_dout[LB]) pkt_count_d = pkt_count_q + CNT_W'(1);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    fifo_skid_buf #(
        .WIDTH (DATA_SIZE + 1)
    ) u_skid (
        .clk   (wclk),
        .rst   (wrst),
        .push  (accept),
        .pop   (pop),
        .din   ({last_tag, bus.s_data}),
        .dout  (buf_dout),
        .empty (buf_empty),
        .ready (buf_ready)
    );

    assign bus.s_ready   = buf_ready;
    assign bus.winc      = pop;
    assign bus.wdata     = buf_dout;
    assign bus.busy      = (state_q == ST_PAYLOAD) | ~buf_empty;
    assign bus.pkt_count = pkt_count_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed vector table, corner sequences, random run vs queue model.
module tb_fifo_wr_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_ctrl_if #(.DATA_SIZE(32)) bus();

    fifo_wr_ctrl #(.DATA_SIZE(32), .LEN_BITS(8)) dut (
        .wclk (clk),
        .wrst (rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words waiting for the FIFO, in order, with their last flag.
    logic [32:0] mq[$];
    bit          m_rdy;
    bit          m_in_pkt;
    int          m_rem;
    logic [15:0] m_cnt;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        wf;
        logic        rdy;
        logic        winc;
        logic [32:0] wdata;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(logic v, logic [31:0] d, logic wf, logic rdy, logic winc,
                                logic [32:0] wdata, logic busy, logic [15:0] cnt);
        vec_t r;
        r.v = v; r.d = d; r.wf = wf; r.rdy = rdy; r.winc = winc;
        r.wdata = wdata; r.busy = busy; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic wf);
        @(negedge clk);
        rst         = 1'b0;
        bus.s_valid = v;
        bus.s_data  = d;
        bus.wfull   = wf;
        #1;
    endtask

    task automatic model_chk();
        bit exp_winc;
        exp_winc = (mq.size() > 0) && !bus.wfull;
        chk("s_ready", 64'(bus.s_ready), 64'(m_rdy));
        chk("winc", 64'(bus.winc), 64'(exp_winc));
        if (exp_winc) chk("wdata", 64'(bus.wdata), 64'(mq[0]));
        chk("busy", 64'(bus.busy), 64'(m_in_pkt || (mq.size() > 0)));
        chk("pkt_count", 64'(bus.pkt_count), 64'(m_cnt));
    endtask

    task automatic tick();
        bit   acc, pop;
        logic last;
        int   n;
        acc = bus.s_valid && m_rdy;
        pop = (mq.size() > 0) && !bus.wfull;
        @(posedge clk);
        if (pop) begin
            if (mq[0][32]) m_cnt = m_cnt + 16'd1;
            void'(mq.pop_front());
        end
        if (acc) begin
            last = 1'b0;
            if (!m_in_pkt) begin
                n = int'(bus.s_data[7:0]);
                if (n == 0) last = 1'b1;
                else begin m_in_pkt = 1'b1; m_rem = n; end
            end else begin
                m_rem--;
                if (m_rem == 0) begin last = 1'b1; m_in_pkt = 1'b0; end
            end
            mq.push_back({last, bus.s_data});
        end
        m_rdy = (mq.size() < 2);
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic wf);
        drive(v, d, wf);
        model_chk();
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.wfull   = 1'b0;
        repeat (2) @(posedge clk);
        mq.delete();
        m_rdy = 1'b0; m_in_pkt = 1'b0; m_rem = 0; m_cnt = '0;
    endtask

    task automatic finish_and_drain();
        for (int i = 0; i < 300 && m_in_pkt; i++) cycle(1'b1, $urandom, 1'b0);
        for (int i = 0; i < 10 && (mq.size() > 0); i++) cycle(1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        chk("drain_busy", 64'(bus.busy), 64'(0));
        model_chk();
        tick();
    endtask

    initial begin
        logic [31:0] pd;
        logic [31:0] d;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.wfull   = 1'b0;

        // Zero-length packet, then a 3-word-payload packet streamed back to back.
        tbl[0] = mk(0, 32'h0,         0, 0, 0, 33'h0,          0, 16'd0);
        tbl[1] = mk(1, 32'h0,         0, 1, 0, 33'h0,          0, 16'd0);
        tbl[2] = mk(0, 32'h0,         0, 1, 1, 33'h1_0000_0000, 1, 16'd0);
        tbl[3] = mk(0, 32'h0,         0, 1, 0, 33'h0,          0, 16'd1);
        tbl[4] = mk(1, 32'h0000_0003, 0, 1, 0, 33'h0,          0, 16'd1);
        tbl[5] = mk(1, 32'hA1A1_0001, 0, 1, 1, 33'h0_0000_0003, 1, 16'd1);
        tbl[6] = mk(1, 32'hA2A2_0002, 0, 1, 1, 33'h0_A1A1_0001, 1, 16'd1);
        tbl[7] = mk(1, 32'hA3A3_0003, 0, 1, 1, 33'h0_A2A2_0002, 1, 16'd1);
        tbl[8] = mk(0, 32'h0,         0, 1, 1, 33'h1_A3A3_0003, 1, 16'd1);
        tbl[9] = mk(0, 32'h0,         0, 1, 0, 33'h0,          0, 16'd2);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].wf);
            chk($sformatf("tbl%0d_s_ready", i), 64'(bus.s_ready), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_winc", i), 64'(bus.winc), 64'(tbl[i].winc));
            if (tbl[i].winc) chk($sformatf("tbl%0d_wdata", i), 64'(bus.wdata), 64'(tbl[i].wdata));
            chk($sformatf("tbl%0d_busy", i), 64'(bus.busy), 64'(tbl[i].busy));
            chk($sformatf("tbl%0d_pkt_count", i), 64'(bus.pkt_count), 64'(tbl[i].cnt));
            model_chk();
            tick();
        end

        // FIFO full for 5 cycles while streaming: two words skid in, then back-pressure.
        pd = 32'h5000_0000;
        cycle(1'b1, 32'h0000_0004, 1'b1);
        cycle(1'b1, pd, 1'b1); pd++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pd, 1'b1);
            chk("stall_s_ready", 64'(bus.s_ready), 64'(0));
            chk("stall_winc", 64'(bus.winc), 64'(0));
            model_chk();
            tick();
        end
        for (int i = 0; i < 20 && m_in_pkt; i++) begin
            drive(1'b1, pd, 1'b0);
            if (bus.s_ready) pd++;
            model_chk();
            tick();
        end
        finish_and_drain();

        // Reset in the middle of a packet; next word must be parsed as a header.
        cycle(1'b1, 32'h0000_0004, 1'b0);
        cycle(1'b1, 32'hB0B0_0001, 1'b0);
        cycle(1'b1, 32'hB0B0_0002, 1'b0);
        do_reset();
        drive(1'b0, 32'h0, 1'b0);
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_winc", 64'(bus.winc), 64'(0));
        chk("rst_pkt_count", 64'(bus.pkt_count), 64'(0));
        model_chk();
        tick();
        cycle(1'b1, 32'hC0C0_C000, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        chk("post_rst_hdr_winc", 64'(bus.winc), 64'(1));
        chk("post_rst_hdr_last", 64'(bus.wdata[32]), 64'(1));
        model_chk();
        tick();
        finish_and_drain();

        // Random traffic and back-pressure against the queue model.
        for (int i = 0; i < 10000; i++) begin
            d = $urandom;
            if (!m_in_pkt) d = (d & 32'hFFFF_FF00) | 32'($urandom_range(0, 5));
            cycle(1'($urandom_range(0, 1)), d, ($urandom_range(0, 9) < 3));
        end
        finish_and_drain();

        // Run the packet counter up to 0xFFFF with zero-length packets, then wrap it.
        for (int i = 0; i < 70000 && (32'(m_cnt) + 32'(mq.size()) < 32'hFFFF); i++)
            cycle(1'b1, 32'h0, 1'b0);
        finish_and_drain();
        drive(1'b0, 32'h0, 1'b0);
        chk("cnt_at_ffff", 64'(bus.pkt_count), 64'(16'hFFFF));
        model_chk();
        tick();
        cycle(1'b1, 32'h0000_0001, 1'b0);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
        finish_and_drain();
        drive(1'b0, 32'h0, 1'b0);
        chk("cnt_wrap", 64'(bus.pkt_count), 64'(16'h0000));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32: command word width.
REQ-002 SHALL have parameter LEN_BITS, default 8: width of the header length field, 1..DATA_SIZE.
REQ-003 SHALL have port wclk, input, 1: single clock.
REQ-004 SHALL have port wrst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port s_valid, input, 1: upstream command word valid.
REQ-006 SHALL have port s_ready, output, 1: block can accept a word.
REQ-007 SHALL have port s_data, input, DATA_SIZE: upstream command word.
REQ-008 SHALL have port wfull, input, 1: registered FIFO full flag from the FIFO write-pointer logic.
REQ-009 SHALL have port winc, output, 1: FIFO write strobe.
REQ-010 SHALL have port wdata, output, DATA_SIZE+1: FIFO write data; bit DATA_SIZE is the last-of-packet flag.
REQ-011 SHALL have port busy, output, 1: high while a packet is open or buffered data is pending.
REQ-012 SHALL have port pkt_count, output, 16: count of completed packets written to the FIFO.

Function
REQ-013 SHALL accept a word on a wclk edge only when s_valid and s_ready are both high.
REQ-014 SHALL hold accepted words in a 2-entry in-order skid buffer; s_ready is registered and equals (occupancy after this edge < 2).
REQ-015 SHALL drive winc = buffer non-empty AND NOT wfull, combinationally, with wdata = head entry; the head pops on that edge.
REQ-016 SHALL give a minimum latency of 1 cycle: a word accepted at edge t can be written at edge t+1.
REQ-017 SHALL allow accept and pop on the same edge, with occupancy unchanged; at occupancy 2, s_ready=0 so there is no accept.
REQ-018 SHALL run the framing FSM on accepted words with states IDLE and PAYLOAD.
REQ-019 IDLE: the accepted word is a header with N = s_data[LEN_BITS-1:0]; N=0 -> tag last=1 and stay IDLE; N>0 -> tag last=0, load remaining=N, go to PAYLOAD.
REQ-020 PAYLOAD: each accepted word decrements remaining; when remaining=1, tag last=1 and go to IDLE; otherwise tag last=0.
REQ-021 SHALL compute the last tag at accept time and store it in the buffer entry alongside the data.
REQ-022 SHALL increment pkt_count on each edge where winc=1 and the popped entry has last=1; the count wraps 0xFFFF->0.
REQ-023 SHALL drive busy = (FSM in PAYLOAD) OR buffer non-empty.
REQ-024 SHALL hold data in the buffer indefinitely while wfull=1; no word is dropped or reordered.
REQ-025 SHALL NOT generate winc while wfull=1, even though the FIFO also gates its increment.

Reset
REQ-026 SHALL, while wrst=1 at a wclk edge, clear the buffer, set the FSM to IDLE, set remaining=0 and pkt_count=0, and drive s_ready=0.
REQ-027 SHALL drive s_ready=1 on the first edge after wrst deasserts; winc=0 and busy=0 until the first accept.
REQ-028 SHALL discard the partial packet and buffered words on reset mid-packet; the next accepted word is a header.

Structure
REQ-029 SHALL place the FSM state enum and the LAST_BIT index constant (=DATA_SIZE) in a shared FIFO package.
REQ-030 SHALL implement the 2-entry skid buffer as sub-module fifo_skid_buf (parameter WIDTH=DATA_SIZE+1), with the framing FSM in the top.

Verification
REQ-031 Reset, then s_valid=1 with header N=0 (0x00000000) and wfull=0 -> winc=1 one cycle later, wdata[32]=1, pkt_count=1.
REQ-032 Header N=3 followed by 3 payload words, back-to-back -> 4 winc pulses; last=1 only on the 4th; pkt_count 0->1; busy=0 after.
REQ-033 wfull=1 for 5 cycles while streaming -> winc=0 throughout, s_ready=0 after 2 accepts; on wfull=0 the data drains in order with no loss.
REQ-034 Assert wrst after 2 payload words of an N=4 packet -> buffer empty, busy=0, pkt_count=0; the next word is treated as a header.
REQ-035 Force pkt_count to 0xFFFF, then complete one packet -> pkt_count=0x0000.
REQ-036 Random s_valid and wfull over 10k cycles against a scoreboard -> FIFO-side sequence equals the input sequence and last flags match the header lengths.
